// File: rtl/mac_pkg.sv
// Shared constants and types for the systolic MAC array front end.
// Holds operand sizing, the loader FSM state type and the memory word type.
package mac_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int NUM_FIFOS     = 9;
    localparam int BYTES_PER_ROW = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        DONE
    } loader_state_t;

    typedef logic [DATA_WIDTH*BYTES_PER_ROW-1:0] row_word_t;

endpackage

// File: rtl/byte_serializer.sv
// Splits one memory word into bytes, most-significant byte first.
// Ports: clk/rst, load+word capture a word, advance shifts one byte out,
// byte_out is the current byte, last flags the final byte of the word.
module byte_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BYTES      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [DATA_WIDTH*BYTES-1:0] word,
    input  logic                        advance,
    output logic [DATA_WIDTH-1:0]       byte_out,
    output logic                        last
);

    localparam int WORD_W = DATA_WIDTH * BYTES;
    localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= word;
            cnt   <= '0;
        end else if (advance) begin
            shreg <= shreg << DATA_WIDTH;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign byte_out = shreg[WORD_W-1 -: DATA_WIDTH];
    assign last     = (cnt == CNT_W'(BYTES - 1));

endmodule

// File: rtl/fifo_loader.sv
// Fetches A rows and the B vector from Avalon-MM memory into 9 operand FIFOs.
// Ports: start/busy/done handshake, Avalon read master (mem_*),
// per-FIFO full flags in, one-hot fifo_wren and shared fifo_wdata out.
module fifo_loader
    import mac_pkg::*;
#(
    parameter int                    DATA_WIDTH    = mac_pkg::DATA_WIDTH,
    parameter int                    NUM_FIFOS     = mac_pkg::NUM_FIFOS,
    parameter int                    BYTES_PER_ROW = mac_pkg::BYTES_PER_ROW,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [ADDR_WIDTH-1:0]               mem_address,
    output logic                                mem_read,
    input  logic                                mem_waitrequest,
    input  logic [DATA_WIDTH*BYTES_PER_ROW-1:0] mem_readdata,
    input  logic                                mem_readdatavalid,
    input  logic [NUM_FIFOS-1:0]                fifo_full,
    output logic [NUM_FIFOS-1:0]                fifo_wren,
    output logic [DATA_WIDTH-1:0]               fifo_wdata
);

    localparam int ROW_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

    loader_state_t   state;
    loader_state_t   state_next;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_next;

    logic                  ser_load;
    logic                  ser_advance;
    logic                  ser_last;
    logic [DATA_WIDTH-1:0] ser_byte;
    logic                  last_row;

    byte_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTES      (BYTES_PER_ROW)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .word     (mem_readdata),
        .advance  (ser_advance),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
        end
    end

    assign last_row = (row == ROW_W'(NUM_FIFOS - 1));

    always_comb begin
        state_next  = state;
        row_next    = row;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        fifo_wren   = '0;
        fifo_wdata  = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                    row_next   = '0;
                end
            end
            REQ: begin
                if (!mem_waitrequest) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_readdatavalid) begin
                    ser_load   = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // Only the selected FIFO's full flag can stall the write.
                fifo_wdata = ser_byte;
                if (!fifo_full[row]) begin
                    fifo_wren   = NUM_FIFOS'(1) << row;
                    ser_advance = 1'b1;
                    if (ser_last) begin
                        if (last_row) begin
                            state_next = DONE;
                        end else begin
                            row_next   = row + ROW_W'(1);
                            state_next = REQ;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Row is stable throughout REQ, so the address holds under waitrequest.
    assign mem_address = BASE_ADDR
                       + (ADDR_WIDTH'(row) * ADDR_WIDTH'(BYTES_PER_ROW));
    assign mem_read    = (state == REQ);
    assign busy        = (state == REQ) || (state == WAIT)
                      || (state == WRITE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_fifo_loader.sv
// Directed self-checking bench for fifo_loader.
// Avalon memory model with stall/latency knobs plus FIFO write logger.
module tb_fifo_loader;
    import mac_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic [31:0]          mem_address;
    logic                 mem_read;
    logic                 mem_waitrequest;
    row_word_t            mem_readdata = '0;
    logic                 mem_readdatavalid;
    logic [NUM_FIFOS-1:0] fifo_full;
    logic [NUM_FIFOS-1:0] fifo_wren;
    logic [7:0]           fifo_wdata;

    int checks = 0;
    int fails  = 0;

    fifo_loader dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .fifo_full         (fifo_full),
        .fifo_wren         (fifo_wren),
        .fifo_wdata        (fifo_wdata)
    );

    always #5 clk = ~clk;

    // Memory model state
    row_word_t   mem [NUM_FIFOS];
    int          lat = 1;
    int          pend = 0;
    logic [31:0] paddr = '0;
    logic        rdv = 1'b0;
    logic        inject = 1'b0;
    int          stall_total = 0;
    int          stall_used = 0;
    int          full_at = -1;
    int          full_cnt = 0;
    int          w2 = 0;

    assign mem_readdatavalid = rdv | inject;
    assign mem_waitrequest   = mem_read && (mem_address == 32'h20)
                            && (stall_used < stall_total);
    assign fifo_full         = (full_cnt > 0) ? 9'h004 : 9'h000;

    always @(posedge clk) begin
        rdv <= 1'b0;
        if (pend == 1) begin
            rdv          <= 1'b1;
            mem_readdata <= mem[paddr[31:3]];
        end
        if (pend > 0) pend <= pend - 1;
        if (mem_read && !mem_waitrequest) begin
            if (lat == 1) begin
                rdv          <= 1'b1;
                mem_readdata <= mem[mem_address[31:3]];
            end else begin
                pend  <= lat - 1;
                paddr <= mem_address;
            end
        end
        if (mem_waitrequest) stall_used <= stall_used + 1;
        if (full_cnt > 0) full_cnt <= full_cnt - 1;
        else if (fifo_wren[2] && (w2 + 1 == full_at)) full_cnt <= 5;
        if (fifo_wren[2]) w2 <= w2 + 1;
    end

    // FIFO write logger
    logic [7:0] q [NUM_FIFOS][$];
    int total_wr = 0;
    int onehot_err = 0;
    int viol = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FIFOS; i++)
                if (fifo_wren[i]) q[i].push_back(fifo_wdata);
            if (fifo_wren != '0) total_wr++;
            if ($countones(fifo_wren) > 1) onehot_err++;
            if (fifo_wren[2] && fifo_full[2]) viol++;
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap(output int b [NUM_FIFOS]);
        for (int r = 0; r < NUM_FIFOS; r++) b[r] = q[r].size();
    endtask

    task automatic check_fifos(input string tag, input int b [NUM_FIFOS]);
        for (int r = 0; r < NUM_FIFOS; r++) begin
            chk($sformatf("%s_cnt%0d", tag, r), 64'(q[r].size() - b[r]), 8);
            for (int k = 0; k < 8; k++)
                chk($sformatf("%s_f%0d_b%0d", tag, r, k),
                    64'(q[r][b[r] + k]), 64'(r * 8 + k));
        end
    endtask

    // Pulses start, then tracks the load until done or the cycle bound.
    task automatic run_load(input int restart_at, output int done_at,
                            output int busy_n, output int held,
                            output logic busy_at_done,
                            output logic [31:0] first_addr,
                            output logic first_read);
        done_at = 0;
        busy_n = 0;
        held = 0;
        busy_at_done = 1'bx;
        first_addr = 'x;
        first_read = 1'bx;
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                first_addr = mem_address;
                first_read = mem_read;
            end
            if (n == restart_at) start = 1'b1;
            if (n == restart_at + 1) start = 1'b0;
            if (mem_read && mem_address == 32'h20) held++;
            if (busy) busy_n++;
            if (done) begin
                done_at = n;
                busy_at_done = busy;
                break;
            end
        end
    endtask

    int          b [NUM_FIFOS];
    int          done_at, busy_n, held, wr0, dc0;
    logic        bad, fread;
    logic [31:0] faddr;

    initial begin
        for (int r = 0; r < NUM_FIFOS; r++)
            for (int k = 0; k < 8; k++)
                mem[r][63 - 8*k -: 8] = 8'(r * 8 + k);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_read", 64'(mem_read), 0);
        chk("rst_wren", 64'(fifo_wren), 0);
        chk("rst_addr", 64'(mem_address), 0);
        chk("rst_wdata", 64'(fifo_wdata), 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain load, no stalls
        snap(b);
        wr0 = total_wr;
        dc0 = done_cnt;
        run_load(0, done_at, busy_n, held, bad, faddr, fread);
        chk("l1_done_at", 64'(done_at), 91);
        chk("l1_busy_n", 64'(busy_n), 90);
        chk("l1_busy_at_done", 64'(bad), 0);
        chk("l1_first_addr", 64'(faddr), 0);
        chk("l1_first_read", 64'(fread), 1);
        repeat (3) @(negedge clk);
        chk("l1_writes", 64'(total_wr - wr0), 72);
        chk("l1_done_pulses", 64'(done_cnt - dc0), 1);
        check_fifos("l1", b);

        // start while busy is ignored
        snap(b);
        wr0 = total_wr;
        dc0 = done_cnt;
        run_load(20, done_at, busy_n, held, bad, faddr, fread);
        chk("rs_done_at", 64'(done_at), 91);
        repeat (5) @(negedge clk);
        chk("rs_writes", 64'(total_wr - wr0), 72);
        chk("rs_done_pulses", 64'(done_cnt - dc0), 1);
        chk("rs_idle_busy", 64'(busy), 0);
        chk("rs_idle_read", 64'(mem_read), 0);

        // waitrequest for 3 cycles on row 4
        snap(b);
        stall_total = stall_used + 3;
        run_load(0, done_at, busy_n, held, bad, faddr, fread);
        chk("wr_done_at", 64'(done_at), 94);
        chk("wr_held", 64'(held), 4);
        check_fifos("wr", b);
        @(negedge clk);

        // fifo_full[2] for 5 cycles after the 3rd write of row 2
        snap(b);
        full_at = w2 + 3;
        run_load(0, done_at, busy_n, held, bad, faddr, fread);
        chk("ff_done_at", 64'(done_at), 96);
        chk("ff_wren_while_full", 64'(viol), 0);
        check_fifos("ff", b);
        @(negedge clk);

        // rst during WRITE of row 3
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        chk("ab_wren_row3", 64'(fifo_wren), 64'h008);
        chk("ab_wdata_row3", 64'(fifo_wdata), 64'h1a);
        rst = 1'b1;
        @(negedge clk);
        chk("ab_busy", 64'(busy), 0);
        chk("ab_done", 64'(done), 0);
        chk("ab_read", 64'(mem_read), 0);
        chk("ab_wren", 64'(fifo_wren), 0);
        chk("ab_addr", 64'(mem_address), 0);
        chk("ab_wdata", 64'(fifo_wdata), 0);
        rst = 1'b0;
        @(negedge clk) inject = 1'b1;
        @(negedge clk) inject = 1'b0;
        chk("stale_busy", 64'(busy), 0);
        chk("stale_wren", 64'(fifo_wren), 0);
        chk("stale_read", 64'(mem_read), 0);
        snap(b);
        run_load(0, done_at, busy_n, held, bad, faddr, fread);
        chk("rl_first_addr", 64'(faddr), 0);
        chk("rl_done_at", 64'(done_at), 91);
        check_fifos("rl", b);
        @(negedge clk);

        // 2-cycle read latency
        snap(b);
        lat = 2;
        run_load(0, done_at, busy_n, held, bad, faddr, fread);
        chk("l2_done_at", 64'(done_at), 100);
        check_fifos("l2", b);

        chk("onehot", 64'(onehot_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
